// File: rtl/spi_regbank_arb_if.sv
// Request/response bundle between the SPI slave / local host requesters and the register bank.
// Handshake: SPI events are 1-cycle strobes with no back-pressure; host_req is a 1-cycle strobe taken
// only when host_busy=0 and the bank is not in its host_ack cycle, answered by exactly one host_ack.
interface spi_regbank_arb_if #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 16
);
   logic              spi_wr_evt;
   logic [DWIDTH-1:0] spi_wr_data;
   logic [AWIDTH-1:0] spi_addr;
   logic              spi_rd_samp_evt;
   logic [DWIDTH-1:0] spi_rd_data;
   logic              host_req;
   logic              host_we;
   logic [AWIDTH-1:0] host_addr;
   logic [DWIDTH-1:0] host_wdata;
   logic              host_busy;
   logic              host_ack;
   logic [DWIDTH-1:0] host_rdata;
   logic              host_err;

   modport master (
      output spi_wr_evt, spi_wr_data, spi_addr, spi_rd_samp_evt,
      output host_req, host_we, host_addr, host_wdata,
      input  spi_rd_data, host_busy, host_ack, host_rdata, host_err
   );

   modport slave (
      input  spi_wr_evt, spi_wr_data, spi_addr, spi_rd_samp_evt,
      input  host_req, host_we, host_addr, host_wdata,
      output spi_rd_data, host_busy, host_ack, host_rdata, host_err
   );
endinterface

// File: rtl/spi_regbank_arb.sv
// Register bank shared by the SPI slave (absolute priority) and a local host port.
// SPI accesses complete the cycle after their event; host commands run only in SPI-free cycles.
module spi_regbank_arb #(
   parameter int                 AWIDTH    = 16,
   parameter int                 DWIDTH    = 16,
   parameter int                 NREG      = 16,
   parameter logic [AWIDTH-1:0]  BASE_ADDR = '0,
   parameter logic [NREG-1:0]    RO_MASK   = '0,
   parameter logic [DWIDTH-1:0]  BAD_DATA  = 16'hBAAD
) (
   input  logic                   user_clk,
   input  logic                   user_rst_n,
   spi_regbank_arb_if.slave       bus,
   input  logic [NREG*DWIDTH-1:0] status_in,
   output logic [NREG*DWIDTH-1:0] cfg_out,
   output logic [NREG-1:0]        cfg_wr_pulse,
   input  logic                   err_clr,
   output logic [7:0]             spi_err_cnt,
   output logic [1:0]             host_state_dbg
);
   localparam int                IW     = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [AWIDTH:0]   NREG_W = (AWIDTH+1)'(NREG);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } host_state_t;

   host_state_t       state;
   logic [DWIDTH-1:0] regs [NREG];
   logic              h_we;
   logic [AWIDTH-1:0] h_addr;
   logic [DWIDTH-1:0] h_wdata;

   logic [AWIDTH-1:0] spi_off, host_off;
   logic              spi_legal, host_legal, spi_ro, host_ro;
   logic [IW-1:0]     spi_idx, host_idx;
   logic [DWIDTH-1:0] spi_rval, host_rval;
   logic              host_exec, spi_wr_ok, host_wr_ok;
   logic [1:0]        spi_bad;
   logic [8:0]        cnt_sum;

   // Address decode and read mux, one copy per requester.
   always_comb begin
      spi_off    = bus.spi_addr - BASE_ADDR;
      spi_legal  = (bus.spi_addr >= BASE_ADDR) && ({1'b0, spi_off} < NREG_W);
      spi_idx    = spi_off[IW-1:0];
      spi_ro     = spi_legal && RO_MASK[spi_idx];
      spi_rval   = BAD_DATA;
      if (spi_legal)
         spi_rval = spi_ro ? status_in[int'(spi_idx)*DWIDTH +: DWIDTH] : regs[spi_idx];

      host_off   = h_addr - BASE_ADDR;
      host_legal = (h_addr >= BASE_ADDR) && ({1'b0, host_off} < NREG_W);
      host_idx   = host_off[IW-1:0];
      host_ro    = host_legal && RO_MASK[host_idx];
      host_rval  = BAD_DATA;
      if (host_legal)
         host_rval = host_ro ? status_in[int'(host_idx)*DWIDTH +: DWIDTH] : regs[host_idx];
   end

   // The host only executes in a cycle with no SPI event, so at most one write lands per cycle.
   assign host_exec  = (state == ST_EXEC) && !bus.spi_wr_evt && !bus.spi_rd_samp_evt;
   assign spi_wr_ok  = bus.spi_wr_evt && spi_legal && !spi_ro;
   assign host_wr_ok = host_exec && h_we && host_legal && !host_ro;

   always_comb begin
      spi_bad = 2'(bus.spi_rd_samp_evt && !spi_legal) + 2'(bus.spi_wr_evt && (!spi_legal || spi_ro));
      cnt_sum = {1'b0, spi_err_cnt} + 9'(spi_bad);
   end

   always_comb begin
      cfg_out = '0;
      for (int i = 0; i < NREG; i++)
         cfg_out[i*DWIDTH +: DWIDTH] = regs[i];
   end

   assign host_state_dbg = state;

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         cfg_wr_pulse    <= '0;
         bus.spi_rd_data <= '0;
      end else begin
         cfg_wr_pulse <= '0;
         if (bus.spi_rd_samp_evt)
            bus.spi_rd_data <= spi_rval;
         if (spi_wr_ok) begin
            regs[spi_idx]         <= bus.spi_wr_data;
            cfg_wr_pulse[spi_idx] <= 1'b1;
         end else if (host_wr_ok) begin
            regs[host_idx]         <= h_wdata;
            cfg_wr_pulse[host_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n)
         spi_err_cnt <= '0;
      else if (err_clr)
         spi_err_cnt <= '0;
      else if (cnt_sum[8])
         spi_err_cnt <= 8'hFF;
      else
         spi_err_cnt <= cnt_sum[7:0];
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state          <= ST_IDLE;
         h_we           <= 1'b0;
         h_addr         <= '0;
         h_wdata        <= '0;
         bus.host_busy  <= 1'b0;
         bus.host_ack   <= 1'b0;
         bus.host_rdata <= '0;
         bus.host_err   <= 1'b0;
      end else begin
         bus.host_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.host_req) begin
                  h_we          <= bus.host_we;
                  h_addr        <= bus.host_addr;
                  h_wdata       <= bus.host_wdata;
                  bus.host_busy <= 1'b1;
                  state         <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (host_exec) begin
                  if (!h_we)
                     bus.host_rdata <= host_rval;
                  bus.host_err  <= !host_legal || (h_we && host_ro);
                  bus.host_ack  <= 1'b1;
                  bus.host_busy <= 1'b0;
                  state         <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_regbank_arb.sv
// Directed + randomized checks of spi_regbank_arb against an array-based model of the register bank.
module tb_spi_regbank_arb;
   localparam int              AW      = 16;
   localparam int              DW      = 16;
   localparam int              NREG    = 16;
   localparam logic [NREG-1:0] RO_MASK = 16'h1080;
   localparam logic [DW-1:0]   BAD     = 16'hBAAD;

   logic                 user_clk   = 1'b0;
   logic                 user_rst_n = 1'b0;
   logic [NREG*DW-1:0]   status_in;
   logic [NREG*DW-1:0]   cfg_out;
   logic [NREG-1:0]      cfg_wr_pulse;
   logic                 err_clr;
   logic [7:0]           spi_err_cnt;
   logic [1:0]           host_state_dbg;

   spi_regbank_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   spi_regbank_arb #(
      .AWIDTH(AW), .DWIDTH(DW), .NREG(NREG), .BASE_ADDR(16'h0000),
      .RO_MASK(RO_MASK), .BAD_DATA(BAD)
   ) dut (
      .user_clk(user_clk), .user_rst_n(user_rst_n), .bus(bus),
      .status_in(status_in), .cfg_out(cfg_out), .cfg_wr_pulse(cfg_wr_pulse),
      .err_clr(err_clr), .spi_err_cnt(spi_err_cnt), .host_state_dbg(host_state_dbg)
   );

   always #5 user_clk = ~user_clk;

   int            test_cnt = 0;
   int            fail_cnt = 0;
   logic [DW-1:0] mreg [NREG];
   logic [DW-1:0] stat [NREG];
   int            merr;

   always_comb begin
      status_in = '0;
      for (int i = 0; i < NREG; i++)
         status_in[i*DW +: DW] = stat[i];
   end

   function automatic logic [DW-1:0] m_read(input int a);
      if (a < 0 || a >= NREG) return BAD;
      if (RO_MASK[a]) return stat[a];
      return mreg[a];
   endfunction

   function automatic bit m_legal(input int a);
      return (a >= 0) && (a < NREG);
   endfunction

   function automatic bit m_rw(input int a);
      return m_legal(a) && !RO_MASK[a];
   endfunction

   function automatic logic [NREG*DW-1:0] m_cfg();
      logic [NREG*DW-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) v[i*DW +: DW] = mreg[i];
      return v;
   endfunction

   function automatic logic [NREG-1:0] m_pulse(input int a);
      logic [NREG-1:0] v;
      v = '0;
      if (m_rw(a)) v[a] = 1'b1;
      return v;
   endfunction

   function automatic void m_err_inc();
      if (merr < 255) merr++;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < NREG; i++) mreg[i] = '0;
      merr = 0;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic spi_write(input int a, input logic [DW-1:0] d);
      bus.spi_wr_evt = 1'b1; bus.spi_addr = AW'(a); bus.spi_wr_data = d;
      tick();
      bus.spi_wr_evt = 1'b0;
      if (m_rw(a)) mreg[a] = d; else m_err_inc();
      check("spi_wr_pulse", 256'(cfg_wr_pulse), 256'(m_pulse(a)));
      check("spi_wr_cfg", 256'(cfg_out), 256'(m_cfg()));
      check("spi_wr_errcnt", 256'(spi_err_cnt), 256'(merr));
   endtask

   task automatic spi_read(input int a);
      logic [DW-1:0] exp;
      exp = m_read(a);
      bus.spi_rd_samp_evt = 1'b1; bus.spi_addr = AW'(a);
      tick();
      bus.spi_rd_samp_evt = 1'b0;
      if (!m_legal(a)) m_err_inc();
      check("spi_rd_data", 256'(bus.spi_rd_data), 256'(exp));
      check("spi_rd_errcnt", 256'(spi_err_cnt), 256'(merr));
      tick();
      check("spi_rd_hold", 256'(bus.spi_rd_data), 256'(exp));
   endtask

   task automatic spi_both(input int wa, input logic [DW-1:0] wd, input int ra);
      logic [DW-1:0] exp;
      exp = m_read(ra);
      bus.spi_wr_evt = 1'b1; bus.spi_rd_samp_evt = 1'b1;
      bus.spi_addr = AW'(wa); bus.spi_wr_data = wd;
      if (wa != ra) begin
         // a single shared address: the read targets the write address in this step
         exp = m_read(wa);
      end
      tick();
      bus.spi_wr_evt = 1'b0; bus.spi_rd_samp_evt = 1'b0;
      if (!m_legal(wa)) m_err_inc();
      if (m_rw(wa)) mreg[wa] = wd; else m_err_inc();
      check("both_rd_prewrite", 256'(bus.spi_rd_data), 256'(exp));
      check("both_cfg", 256'(cfg_out), 256'(m_cfg()));
      check("both_errcnt", 256'(spi_err_cnt), 256'(merr));
   endtask

   // dkind: 0 = SPI read during each deferral cycle, 1 = SPI write (data dd+k)
   task automatic host_op(input bit we, input int a, input logic [DW-1:0] wd,
                          input int ndefer, input int dkind, input int da, input logic [DW-1:0] dd);
      logic [DW-1:0] exp_r;
      int cyc;
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = AW'(a); bus.host_wdata = wd;
      tick();
      bus.host_req = 1'b0;
      check("host_busy_set", 256'(bus.host_busy), 256'(1));
      for (int k = 0; k < ndefer; k++) begin
         bus.spi_addr = AW'(da);
         exp_r = m_read(da);
         if (dkind == 0) bus.spi_rd_samp_evt = 1'b1;
         else begin bus.spi_wr_evt = 1'b1; bus.spi_wr_data = dd + DW'(k); end
         tick();
         bus.spi_rd_samp_evt = 1'b0; bus.spi_wr_evt = 1'b0;
         if (dkind == 0) begin
            if (!m_legal(da)) m_err_inc();
            check("defer_rd_data", 256'(bus.spi_rd_data), 256'(exp_r));
         end else begin
            if (m_rw(da)) mreg[da] = dd + DW'(k); else m_err_inc();
            check("defer_wr_pulse", 256'(cfg_wr_pulse), 256'(m_pulse(da)));
         end
         check("defer_no_ack", 256'(bus.host_ack), 256'(0));
      end
      exp_r = m_read(a);
      cyc = 0;
      while (bus.host_ack !== 1'b1 && cyc < 8) begin
         tick();
         cyc++;
      end
      check("host_ack_latency", 256'(cyc), 256'(1));
      check("host_err", 256'(bus.host_err), 256'(!m_legal(a) || (we && !m_rw(a))));
      check("host_busy_clr", 256'(bus.host_busy), 256'(0));
      if (we) begin
         check("host_wr_pulse", 256'(cfg_wr_pulse), 256'(m_pulse(a)));
         if (m_rw(a)) mreg[a] = wd;
      end else begin
         check("host_rdata", 256'(bus.host_rdata), 256'(exp_r));
      end
      check("host_cfg", 256'(cfg_out), 256'(m_cfg()));
      check("host_errcnt", 256'(spi_err_cnt), 256'(merr));
      tick();
      check("host_ack_1cyc", 256'(bus.host_ack), 256'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      bus.spi_wr_evt = 1'b0; bus.spi_wr_data = '0; bus.spi_addr = '0; bus.spi_rd_samp_evt = 1'b0;
      bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      err_clr = 1'b0;
      for (int i = 0; i < NREG; i++) stat[i] = DW'($urandom_range(0, 65535));
      stat[7] = 16'hCAFE;
      m_reset();

      // T1 reset
      tick(); tick();
      user_rst_n = 1'b1;
      tick();
      check("rst_cfg", 256'(cfg_out), 256'(0));
      check("rst_rd_data", 256'(bus.spi_rd_data), 256'(0));
      check("rst_busy", 256'(bus.host_busy), 256'(0));
      check("rst_ack", 256'(bus.host_ack), 256'(0));
      check("rst_errcnt", 256'(spi_err_cnt), 256'(0));

      // T2 SPI write then read back
      spi_write(3, 16'h1234);
      tick();
      check("t2_pulse_1cyc", 256'(cfg_wr_pulse), 256'(0));
      spi_read(3);

      // T3 host write deferred by two SPI reads
      host_op(1'b1, 5, 16'hA5A5, 2, 0, 3, 16'h0000);

      // T4 read-only register
      spi_write(7, 16'h5555);
      check("t4_errcnt_one", 256'(spi_err_cnt), 256'(1));
      host_op(1'b0, 7, 16'h0000, 0, 0, 0, 16'h0000);
      host_op(1'b1, 7, 16'h7777, 0, 0, 0, 16'h0000);

      // Same-register contention: deferred host write lands after two SPI writes
      host_op(1'b1, 9, 16'hBEEF, 2, 1, 9, 16'h1111);
      // Simultaneous SPI read and write of one register returns the old value
      spi_both(9, 16'h4242, 9);
      // Host read of illegal address
      host_op(1'b0, 20, 16'h0000, 1, 0, 5, 16'h0000);

      // Randomized mix
      for (int n = 0; n < 80; n++) begin
         int op, a;
         logic [DW-1:0] d;
         op = $urandom_range(0, 3);
         a  = $urandom_range(0, NREG + 3);
         d  = DW'($urandom_range(0, 65535));
         case (op)
            0: spi_write(a, d);
            1: spi_read(a);
            2: spi_both(a, d, a);
            default: host_op(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 2),
                             $urandom_range(0, 1), $urandom_range(0, NREG + 3),
                             DW'($urandom_range(0, 65535)));
         endcase
      end

      // T5 out-of-range read, saturation, clear priority
      spi_read(NREG);
      for (int k = 0; k < 300; k++) begin
         bus.spi_rd_samp_evt = 1'b1; bus.spi_addr = AW'(NREG + (k % 4));
         tick();
         m_err_inc();
      end
      bus.spi_rd_samp_evt = 1'b0;
      check("t5_saturate", 256'(spi_err_cnt), 256'(merr));
      check("t5_sat_ff", 256'(spi_err_cnt), 256'(8'hFF));
      err_clr = 1'b1; bus.spi_wr_evt = 1'b1; bus.spi_addr = AW'(NREG + 1); bus.spi_wr_data = 16'h0001;
      tick();
      err_clr = 1'b0; bus.spi_wr_evt = 1'b0;
      merr = 0;
      check("t5_clr_wins", 256'(spi_err_cnt), 256'(0));
      check("t5_cfg_intact", 256'(cfg_out), 256'(m_cfg()));

      // T6 reset while a host command is in flight
      spi_write(2, 16'h3C3C);
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = AW'(4); bus.host_wdata = 16'h9999;
      tick();
      bus.host_req = 1'b0;
      check("t6_busy", 256'(bus.host_busy), 256'(1));
      #2 user_rst_n = 1'b0;
      #1;
      m_reset();
      check("t6_rst_cfg", 256'(cfg_out), 256'(0));
      check("t6_rst_busy", 256'(bus.host_busy), 256'(0));
      check("t6_rst_ack", 256'(bus.host_ack), 256'(0));
      check("t6_rst_rd", 256'(bus.spi_rd_data), 256'(0));
      tick(); tick();
      user_rst_n = 1'b1;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.host_ack === 1'b1) acks++;
      end
      check("t6_no_ack", 256'(acks), 256'(0));
      check("t6_regs_zero", 256'(cfg_out), 256'(0));
      host_op(1'b1, 4, 16'h8181, 0, 0, 0, 16'h0000);
      host_op(1'b0, 4, 16'h0000, 1, 1, 4, 16'h2222);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end
endmodule
